// File: rtl/axil_reg_pkg.sv
// axil_reg_pkg: response codes, channel FSM states and byte-strobe merge for axil_reg_bank
package axil_reg_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACCEPT, R_DATA} rd_state_t;

    function automatic logic [MAX_W-1:0] strb_merge(
        input logic [MAX_W-1:0]   old_v,
        input logic [MAX_W-1:0]   new_v,
        input logic [MAX_W/8-1:0] strb
    );
        logic [MAX_W-1:0] r;
        for (int b = 0; b < MAX_W/8; b++) r[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        return r;
    endfunction

endpackage

// File: rtl/axil_reg_bank.sv
// axil_reg_bank: AXI4-Lite register bank with RW control and RO status registers
module axil_reg_bank
    import axil_reg_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8,
    parameter int NUM_RW   = 4,
    localparam int ADDR_W  = $clog2(NUM_REGS) + $clog2(DATA_W/8)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [ADDR_W-1:0]                   awaddr,
    input  logic                                awvalid,
    output logic                                awready,
    input  logic [DATA_W-1:0]                   wdata,
    input  logic [DATA_W/8-1:0]                 wstrb,
    input  logic                                wvalid,
    output logic                                wready,
    output logic [1:0]                          bresp,
    output logic                                bvalid,
    input  logic                                bready,
    input  logic [ADDR_W-1:0]                   araddr,
    input  logic                                arvalid,
    output logic                                arready,
    output logic [DATA_W-1:0]                   rdata,
    output logic [1:0]                          rresp,
    output logic                                rvalid,
    input  logic                                rready,
    output logic [NUM_RW*DATA_W-1:0]            rw_regs,
    input  logic [(NUM_REGS-NUM_RW)*DATA_W-1:0] ro_regs,
    output logic [NUM_RW-1:0]                   wr_pulse
);

    localparam int OFF_W = $clog2(DATA_W/8);
    localparam int IDX_W = $clog2(NUM_REGS);

    if (DATA_W != 32 && DATA_W != 64) $error("DATA_W must be 32 or 64");
    if (NUM_REGS < 4 || (NUM_REGS & (NUM_REGS-1)) != 0) $error("NUM_REGS must be a power of 2 >= 4");
    if (NUM_RW < 1 || NUM_RW >= NUM_REGS) $error("NUM_RW out of range");

    wr_state_t                           wr_state_q, wr_state_d;
    rd_state_t                           rd_state_q, rd_state_d;
    logic [NUM_RW-1:0][DATA_W-1:0]       regs_q, regs_d;
    logic [NUM_RW-1:0]                   pulse_q, pulse_d;
    logic [1:0]                          bresp_q, bresp_d;
    logic [DATA_W-1:0]                   rdata_q, rdata_d;
    logic [NUM_REGS-1:0][DATA_W-1:0]     all_regs;
    logic [IDX_W-1:0]                    widx, ridx;
    logic                                wr_rw;
    logic                                unused_offsets;

    assign widx           = awaddr[ADDR_W-1:OFF_W];
    assign ridx           = araddr[ADDR_W-1:OFF_W];
    assign unused_offsets = ^{awaddr[OFF_W-1:0], araddr[OFF_W-1:0]};
    assign wr_rw          = widx < IDX_W'(NUM_RW);
    assign all_regs       = {ro_regs, regs_q};

    assign awready  = wr_state_q == W_ACCEPT;
    assign wready   = wr_state_q == W_ACCEPT;
    assign bvalid   = wr_state_q == W_RESP;
    assign bresp    = bresp_q;
    assign wr_pulse = pulse_q;
    assign rw_regs  = regs_q;
    assign arready  = rd_state_q == R_ACCEPT;
    assign rvalid   = rd_state_q == R_DATA;
    assign rdata    = rdata_q;
    assign rresp    = RESP_OKAY;

    always_comb begin
        wr_state_d = wr_state_q;
        regs_d     = regs_q;
        bresp_d    = bresp_q;
        pulse_d    = '0;
        if (wr_state_q == W_IDLE && awvalid && wvalid) wr_state_d = W_ACCEPT;
        if (wr_state_q == W_ACCEPT) begin
            wr_state_d = W_RESP;
            bresp_d    = wr_rw ? RESP_OKAY : RESP_SLVERR;
            for (int i = 0; i < NUM_RW; i++) begin
                if (wr_rw && widx == IDX_W'(i)) begin
                    regs_d[i]  = DATA_W'(strb_merge(MAX_W'(regs_q[i]), MAX_W'(wdata), (MAX_W/8)'(wstrb)));
                    pulse_d[i] = 1'b1;
                end
            end
        end
        if (wr_state_q == W_RESP && bready) wr_state_d = W_IDLE;
    end

    // RW registers are read from their pre-write value when a write lands on the same edge
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        if (rd_state_q == R_IDLE && arvalid) rd_state_d = R_ACCEPT;
        if (rd_state_q == R_ACCEPT) begin
            rd_state_d = R_DATA;
            rdata_d    = all_regs[ridx];
        end
        if (rd_state_q == R_DATA && rready) rd_state_d = R_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            regs_q     <= '0;
            pulse_q    <= '0;
            bresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            regs_q     <= regs_d;
            pulse_q    <= pulse_d;
            bresp_q    <= bresp_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_axil_reg_bank.sv
// tb_axil_reg_bank: scoreboard bench for axil_reg_bank (32-bit, 8 regs, 4 RW)
module tb_axil_reg_bank;

    localparam int DW  = 32;
    localparam int NR  = 8;
    localparam int NRW = 4;
    localparam int AW  = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [AW-1:0]        awaddr, araddr;
    logic                 awvalid, awready, wvalid, wready, bvalid, bready;
    logic                 arvalid, arready, rvalid, rready;
    logic [DW-1:0]        wdata, rdata;
    logic [DW/8-1:0]      wstrb;
    logic [1:0]           bresp, rresp;
    logic [NRW*DW-1:0]    rw_regs;
    logic [(NR-NRW)*DW-1:0] ro_regs;
    logic [NRW-1:0]       wr_pulse;

    logic [DW-1:0] model [NRW];
    logic [DW-1:0] ro [NR-NRW];
    logic [DW-1:0] rq [$];
    logic [1:0]    bq [$];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign ro_regs = {ro[3], ro[2], ro[1], ro[0]};

    axil_reg_bank #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RW(NRW)) dut (
        .clk(clk), .reset(reset),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .rw_regs(rw_regs), .ro_regs(ro_regs), .wr_pulse(wr_pulse)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        return sel == 0 ? awready : sel == 1 ? bvalid : sel == 2 ? arready : rvalid;
    endfunction

    task automatic wait_for(input string tag, input int sel);
        int n;
        n = 0;
        while (!sig(sel) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!sig(sel)) chk({tag, "_timeout"}, 0, 1);
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] d, input logic [3:0] s);
        logic [DW-1:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = s[b] ? d[b*8 +: 8] : o[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [NRW*DW-1:0] model_flat();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
        int idx;
        logic [3:0] ep;
        idx = int'(a[4:2]);
        ep  = idx < NRW ? 4'(1 << idx) : 4'b0;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        bq.push_back(idx < NRW ? 2'b00 : 2'b10);
        if (idx < NRW) model[idx] = merge(model[idx], d, s);
        wait_for("awready", 0);
        chk("wready", wready, 1);
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        wait_for("bvalid", 1);
        chk("bresp", bresp, bq.pop_front());
        chk("wr_pulse", wr_pulse, ep);
        chk("rw_regs", rw_regs, model_flat());
        @(negedge clk);
        chk("wr_pulse_clr", wr_pulse, 0);
        chk("bvalid_clr", bvalid, 0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        int idx;
        idx = int'(a[4:2]);
        @(negedge clk);
        araddr = a; arvalid = 1;
        rq.push_back(idx < NRW ? model[idx] : ro[idx-NRW]);
        wait_for("arready", 2);
        @(negedge clk);
        arvalid = 0;
        wait_for("rvalid", 3);
        chk("rdata", rdata, rq.pop_front());
        chk("rresp", rresp, 0);
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; awaddr = 0; araddr = 0; awvalid = 0; wvalid = 0; arvalid = 0;
        wdata = 0; wstrb = 0; bready = 1; rready = 1;
        ro[0] = 32'h44; ro[1] = 32'h55; ro[2] = 32'h66; ro[3] = 32'h77;
        for (int i = 0; i < NRW; i++) model[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {awready, wready, arready}, 0);
        chk("rst_valid", {bvalid, rvalid}, 0);
        chk("rst_pulse", wr_pulse, 0);
        chk("rst_regs", rw_regs, 0);
        chk("rst_resp", {bresp, rresp}, 0);
        chk("rst_rdata", rdata, 0);
        reset = 0;

        wr(5'd0, 32'h0000_00F0, 4'hF);
        wr(5'd4, 32'h0000_000F, 4'hF);
        for (int i = 0; i < NR; i++) rd(5'(i * 4));

        wr(5'd8, 32'h1122_3344, 4'hF);
        wr(5'd8, 32'hAABB_CCDD, 4'b0101);
        chk("strb_model", model[2], 32'h11BB_33DD);
        rd(5'd8);

        wr(5'd20, 32'hDEAD_BEEF, 4'hF);
        rd(5'd20);
        wr(5'd14, 32'h9999_9999, 4'h0);
        rd(5'd12);

        bready = 0;
        @(negedge clk);
        awaddr = 5'd4; wdata = 32'h1234_5678; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        bq.push_back(2'b00);
        model[1] = 32'h1234_5678;
        wait_for("bp_awready", 0);
        @(negedge clk);
        awaddr = 5'd8; wdata = 32'h0BAD_CAFE;
        for (int i = 0; i < 5; i++) begin
            chk("bp_bvalid", bvalid, 1);
            chk("bp_ready", {awready, wready}, 0);
            chk("bp_regs", rw_regs, model_flat());
            @(negedge clk);
        end
        chk("bp_bresp", bresp, bq.pop_front());
        bready = 1;
        bq.push_back(2'b00);
        model[2] = 32'h0BAD_CAFE;
        wait_for("bp2_awready", 0);
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        wait_for("bp2_bvalid", 1);
        chk("bp2_bresp", bresp, bq.pop_front());
        chk("bp2_pulse", wr_pulse, 4'b0100);
        chk("bp2_regs", rw_regs, model_flat());
        @(negedge clk);

        rready = 0;
        @(negedge clk);
        araddr = 5'd24; arvalid = 1;
        rq.push_back(ro[2]);
        wait_for("rbp_arready", 2);
        @(negedge clk);
        arvalid = 0;
        wait_for("rbp_rvalid", 3);
        ro[2] = 32'h0000_1234;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rbp_rvalid", rvalid, 1);
            chk("rbp_rdata", rdata, rq[0]);
        end
        rready = 1;
        chk("rbp_final", rdata, rq.pop_front());
        @(negedge clk);
        chk("rbp_rvalid_clr", rvalid, 0);
        ro[2] = 32'h66;

        @(negedge clk);
        awaddr = 5'd12; wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1; awvalid = 0;
        bq.push_back(2'b00);
        model[3] = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("early_w_ready", {awready, wready}, 0);
        end
        awvalid = 1;
        @(negedge clk);
        chk("early_w_both", {awready, wready}, 2'b11);
        awvalid = 0; wvalid = 0;
        @(negedge clk);
        chk("early_w_bvalid", bvalid, 1);
        chk("early_w_bresp", bresp, bq.pop_front());
        chk("early_w_regs", rw_regs, model_flat());
        @(negedge clk);

        bready = 0; rready = 0;
        @(negedge clk);
        awaddr = 5'd0; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        wait_for("rst_w_awready", 0);
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        araddr = 5'd4; arvalid = 1;
        wait_for("rst_r_arready", 2);
        @(negedge clk);
        arvalid = 0;
        wait_for("rst_r_rvalid", 3);
        chk("rst_pre_bvalid", bvalid, 1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("rst_mid_valid", {bvalid, rvalid}, 0);
        chk("rst_mid_regs", rw_regs, 0);
        chk("rst_mid_pulse", wr_pulse, 0);
        bready = 1; rready = 1;
        for (int i = 0; i < NRW; i++) model[i] = '0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_resp", {bvalid, rvalid}, 0);
        end
        for (int i = 0; i < NRW; i++) rd(5'(i * 4));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_reg_bank.md
Name: axil_reg_bank

Overview:
Parametrised AXI4-Lite slave register bank; next generation of the fixed 8×32-bit register IP that the PS accesses at its base address (e.g. 0x43C0_0000). The low registers are software read/write and drive PL user logic; the high registers are read-only status sampled from PL inputs. Adds byte strobes, per-register write pulses, SLVERR on illegal writes, and independent read/write channel FSMs with backpressure.

Parameters:
DATA_W, 32, data width in bits; must be 32 or 64.
NUM_REGS, 8, total registers; power of 2, at least 4.
NUM_RW, 4, registers 0..NUM_RW-1 are read/write; NUM_RW..NUM_REGS-1 are read-only; 1 ≤ NUM_RW < NUM_REGS.
ADDR_W (localparam), $clog2(NUM_REGS)+$clog2(DATA_W/8), byte-address width.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
awaddr  in  ADDR_W  write address (byte)
awvalid / awready  in / out  1  write-address handshake
wdata  in  DATA_W  write data
wstrb  in  DATA_W/8  byte enables
wvalid / wready  in / out  1  write-data handshake
bresp  out  2  write response
bvalid / bready  out / in  1  write-response handshake
araddr  in  ADDR_W  read address (byte)
arvalid / arready  in / out  1  read-address handshake
rdata  out  DATA_W  read data
rresp  out  2  read response (always OKAY)
rvalid / rready  out / in  1  read-data handshake
rw_regs  out  NUM_RW*DATA_W  current RW register contents; reg i at [i*DATA_W +: DATA_W]
ro_regs  in  (NUM_REGS-NUM_RW)*DATA_W  status inputs; slice j is register NUM_RW+j
wr_pulse  out  NUM_RW  one-cycle strobe per RW register on a successful write

Behaviour:
- One clock; reset is synchronous and active-high. Reset values: all RW registers 0; awready, wready, bvalid, arready, rvalid, wr_pulse all 0; bresp, rresp, rdata 0; both FSMs in IDLE.
- Register index = addr[ADDR_W-1 : $clog2(DATA_W/8)]; low byte-offset bits ignored.
- Write FSM W_IDLE → W_ACCEPT → W_RESP → W_IDLE.
  - W_IDLE: go to W_ACCEPT when awvalid && wvalid; the address and data may arrive in either order, and the FSM waits for both.
  - W_ACCEPT (1 cycle): awready = wready = 1. At the ending edge:
    - RW index: merge wdata into the register per byte, keeping old bytes where wstrb is 0; set bresp = OKAY (2'b00).
    - RO index: no state change; bresp = SLVERR (2'b10).
  - W_RESP: bvalid = 1; wr_pulse[i] is high only in the first W_RESP cycle, and only for an RW write. Return to W_IDLE on bvalid && bready.
  - No new write is accepted while bvalid = 1.
  - Latency: aw/w valid in cycle 0 → ready in cycle 1 → bvalid in cycle 2; the register value is visible on rw_regs in cycle 2.
  - A write with wstrb = 0 to an RW register is OKAY, leaves the value unchanged and still pulses wr_pulse.
- Read FSM R_IDLE → R_ACCEPT → R_DATA → R_IDLE.
  - R_IDLE: go to R_ACCEPT on arvalid.
  - R_ACCEPT (1 cycle): arready = 1; rdata is latched from the indexed register, or from the ro_regs slice, at the ending edge.
  - R_DATA: rvalid = 1; rdata and rresp = OKAY are held stable until rready, then return to R_IDLE.
  - Latency: arvalid in cycle 0 → rvalid in cycle 2.
- Read and write FSMs are fully independent. If a read latches at the same edge as a write updates the same register, the read returns the pre-write value.
- ro_regs is sampled, not registered, at the R_ACCEPT edge; the PL guarantees it is synchronous to clk.
- Reset asserted mid-transaction: the next edge forces reset values, the outstanding transaction is dropped, and no bvalid/rvalid is emitted for it.

Decomposition:
- Package axil_reg_pkg:
  - resp constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;
  - wr_state_t {W_IDLE, W_ACCEPT, W_RESP} and rd_state_t {R_IDLE, R_ACCEPT, R_DATA};
  - function strb_merge(old, new, strb).
- No sub-module required; both channel FSMs live in the one module.

Test Plan:
- Write 0x0000_00F0 to reg0 and 0x0000_000F to reg1 (strb 0xF), then read regs 0–7 → reg0 = 0xF0, reg1 = 0x0F, reg2–3 = 0, reg4–7 = ro_regs slices (drive 0x44,0x55,0x66,0x77); rresp = 00; wr_pulse = 4'b0001 then 4'b0010, one cycle each.
- reg2 = 0x1122_3344; write 0xAABB_CCDD with wstrb = 4'b0101 → readback 0x11BB_33DD.
- Write 0xDEAD_BEEF to reg5 (RO) → bresp = 2'b10, wr_pulse = 0, read reg5 still returns the ro_regs value.
- Hold bready = 0 for 5 cycles after a write while presenting a second write → bvalid stays high, awready/wready stay 0; the second write is accepted only after the B handshake. Same check with rready low on the read channel: rdata stays stable.
- Present wvalid 3 cycles before awvalid → awready and wready rise together, 1 cycle after awvalid.
- Assert reset during W_RESP and during R_DATA → next cycle bvalid = rvalid = 0, all RW registers read back 0.
